// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Branch resolution and redirect unit for the pipelined RV32I core (EX stage).
// Decodes the branch outcome from the comparator flags, detects mispredicts
// for conditional branches and jumps, keeps a direct-mapped table of 2-bit
// saturating counters for IF-stage prediction, and issues a registered
// one-cycle redirect/flush pulse followed by a one-cycle squash window.
//
// Handshake: there is no valid/ready back-pressure. ex_valid qualifies the
// EX instruction for exactly the cycle it is presented; the unit accepts it
// unconditionally in IDLE and silently drops it in REDIRECT/SQUASH (wrong path).
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   if_pc             : fetch PC for the prediction lookup
//   if_pred_taken     : combinational prediction (counter MSB)
//   ex_valid          : EX holds a real instruction
//   ex_is_branch      : EX instruction is a conditional branch
//   ex_is_jump        : EX instruction is JAL/JALR (wins over ex_is_branch)
//   ex_funct3         : branch funct3
//   ex_pc, ex_target  : EX PC and computed taken target
//   ex_pred_taken     : prediction carried with the instruction
//   BrEq, BrLT        : comparator flags
//   BrUn              : comparator unsigned select (ex_funct3[1])
//   redirect          : registered, PC loads redirect_pc
//   redirect_pc       : registered corrected PC
//   flush             : registered, clears IF/ID and ID/EX
//   squash_active     : high while in REDIRECT or SQUASH
//   br_count          : resolved conditional branches
//   mispred_count     : mispredicts (branches and jumps)
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             BrUn,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             squash_active,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       table_q [ENTRIES];
    logic [1:0]       table_d [ENTRIES];
    logic             redirect_q, redirect_d;
    logic             flush_q, flush_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic             actual_taken;
    logic             funct3_ok;
    logic             eff;
    logic             is_cond_br;
    logic             tbl_upd;
    logic             mispredict;
    logic [31:0]      correct_pc;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;

    // Only the word-index bits of if_pc take part in the lookup.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // ------------------------------------------------------------------
    // Outcome decode
    // ------------------------------------------------------------------
    always_comb begin
        actual_taken = 1'b0;
        funct3_ok    = 1'b0;
        if (ex_is_jump) begin
            // Jumps are always taken; funct3 carries no branch meaning.
            actual_taken = 1'b1;
        end else begin
            case (ex_funct3)
                3'b000: begin actual_taken = BrEq;  funct3_ok = 1'b1; end
                3'b001: begin actual_taken = !BrEq; funct3_ok = 1'b1; end
                3'b100,
                3'b110: begin actual_taken = BrLT;  funct3_ok = 1'b1; end
                3'b101,
                3'b111: begin actual_taken = !BrLT; funct3_ok = 1'b1; end
                default: begin
                    // 010/011 are not branches: never taken, never counted.
                    actual_taken = 1'b0;
                    funct3_ok    = 1'b0;
                end
            endcase
        end
    end

    assign BrUn = ex_funct3[1];

    // Instructions arriving while a redirect is in flight are wrong-path.
    assign eff        = ex_valid & (state_q == IDLE);
    assign is_cond_br = ex_is_branch & ~ex_is_jump & funct3_ok;
    assign tbl_upd    = eff & is_cond_br;
    assign mispredict = eff & (ex_is_branch | ex_is_jump)
                        & (actual_taken != ex_pred_taken);
    assign correct_pc = actual_taken ? ex_target : (ex_pc + 32'd4);

    assign upd_idx    = ex_pc[IDX_W+1:2];
    assign lookup_idx = if_pc[IDX_W+1:2];

    // Lookup reads the registered table, so a same-cycle update to the same
    // index is seen only from the next cycle.
    assign if_pred_taken = table_q[lookup_idx][1];

    // ------------------------------------------------------------------
    // Prediction table next state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            table_d[i] = table_q[i];
        end
        if (tbl_upd) begin
            if (actual_taken) begin
                if (table_q[upd_idx] != 2'b11) begin
                    table_d[upd_idx] = table_q[upd_idx] + 2'b01;
                end
            end else begin
                if (table_q[upd_idx] != 2'b00) begin
                    table_d[upd_idx] = table_q[upd_idx] - 2'b01;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        redirect_d      = 1'b0;
        flush_d         = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;

        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: state_d = SQUASH;
            SQUASH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (mispredict) begin
            redirect_d      = 1'b1;
            flush_d         = 1'b1;
            redirect_pc_d   = correct_pc;
            mispred_count_d = mispred_count_q + CNT_W'(1);
        end

        if (tbl_upd) begin
            br_count_d = br_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            redirect_q      <= 1'b0;
            flush_q         <= 1'b0;
            redirect_pc_q   <= 32'd0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else begin
            state_q         <= state_d;
            redirect_q      <= redirect_d;
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign redirect      = redirect_q;
    assign flush         = flush_q;
    assign redirect_pc   = redirect_pc_q;
    assign squash_active = (state_q == REDIRECT) || (state_q == SQUASH);
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
`timescale 1ns/1ps
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        BrEq;
    logic        BrLT;
    logic        BrUn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        squash_active;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_tbl [16];
    int          m_win;          // remaining wrong-path cycles after a mispredict
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic        exp_redirect;
    logic [31:0] exp_rpc;

    branch_resolve #(.IDX_W(4), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jump    (ex_is_jump),
        .ex_funct3     (ex_funct3),
        .ex_pc         (ex_pc),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .BrEq          (BrEq),
        .BrLT          (BrLT),
        .BrUn          (BrUn),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .squash_active (squash_active),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 16; i++) m_tbl[i] = 1;
        m_win        = 0;
        m_br         = 0;
        m_mis        = 0;
        exp_redirect = 1'b0;
        exp_rpc      = 32'd0;
    endtask

    // Advance the model by one cycle using the inputs currently driven.
    task automatic model_step();
        bit eff, tk, f3ok, mis;
        int i;
        eff  = ex_valid && (m_win == 0);
        tk   = ex_is_jump ? 1'b1 : branch_taken(ex_funct3, BrEq, BrLT);
        f3ok = (ex_funct3 != 3'd2) && (ex_funct3 != 3'd3);
        mis  = eff && (ex_is_branch || ex_is_jump) && (tk != ex_pred_taken);
        if (eff && ex_is_branch && !ex_is_jump && f3ok) begin
            m_br = m_br + 1;
            i = int'(ex_pc[5:2]);
            if (tk) m_tbl[i] = (m_tbl[i] == 3) ? 3 : m_tbl[i] + 1;
            else    m_tbl[i] = (m_tbl[i] == 0) ? 0 : m_tbl[i] - 1;
        end
        exp_redirect = mis;
        if (mis) begin
            m_mis   = m_mis + 1;
            exp_rpc = tk ? ex_target : ex_pc + 32'd4;
            m_win   = 2;
        end else if (m_win > 0) begin
            m_win = m_win - 1;
        end
    endtask

    task automatic tick();
        #1;
        check("br_un", 32'(BrUn), 32'(ex_funct3[1]));
        check("if_pred_taken", 32'(if_pred_taken), 32'(m_tbl[if_pc[5:2]] >= 2));
        model_step();
        @(posedge clk);
        #1;
        check("redirect", 32'(redirect), 32'(exp_redirect));
        check("flush", 32'(flush), 32'(exp_redirect));
        if (exp_redirect) check("redirect_pc", redirect_pc, exp_rpc);
        check("squash_active", 32'(squash_active), 32'(m_win > 0));
        check("br_count", br_count, m_br);
        check("mispred_count", mispred_count, m_mis);
    endtask

    task automatic set_ex(input logic v, input logic br, input logic jmp, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                          input logic eq, input logic lt);
        ex_valid      = v;
        ex_is_branch  = br;
        ex_is_jump    = jmp;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        BrEq          = eq;
        BrLT          = lt;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst   = 1'b1;
        if_pc = 32'd0;
        idle();
        reset_model();
        #3;
        check("rst_redirect", 32'(redirect), 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_squash", 32'(squash_active), 32'd0);
        check("rst_br_count", br_count, 32'd0);
        check("rst_mispred_count", mispred_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            check("rst_if_pred", 32'(if_pred_taken), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // ---------------- taken BEQ predicted not-taken ----------------
        set_ex(1, 1, 0, 3'b000, 32'h100, 32'h80, 0, 1, 0);
        if_pc = 32'h100;
        tick();
        idle();
        tick();
        tick();
        tick();   // if_pc=0x100 now reads entry 0 at 2 -> predict taken

        // ---------------- BGEU not taken? (BrLT=0 -> taken, predicted taken) ---------------
        set_ex(1, 1, 0, 3'b111, 32'h200, 32'h300, 1, 0, 0);
        tick();
        set_ex(1, 1, 0, 3'b111, 32'hFFFF_FFFC, 32'h1000, 1, 0, 1);
        tick();
        idle();
        tick();
        tick();

        // ---------------- saturation at PC 0x40 ----------------
        if_pc = 32'h40;
        for (int k = 0; k < 5; k++) begin
            set_ex(1, 1, 0, 3'b000, 32'h40, 32'h400, 1, 1, 0);
            tick();
        end
        idle();
        tick();
        for (int k = 0; k < 5; k++) begin
            set_ex(1, 1, 0, 3'b001, 32'h40, 32'h400, 0, 1, 0);
            tick();
        end
        idle();
        tick();

        // ---------------- squash window ----------------
        set_ex(1, 1, 0, 3'b000, 32'h80, 32'h800, 0, 1, 0);
        tick();
        set_ex(1, 1, 0, 3'b000, 32'h84, 32'h900, 0, 1, 0);
        tick();
        set_ex(1, 0, 1, 3'b000, 32'h88, 32'hA00, 0, 0, 0);
        tick();
        set_ex(1, 1, 0, 3'b100, 32'h8C, 32'hB00, 0, 0, 1);
        tick();
        idle();
        tick();
        tick();

        // ---------------- reset mid-REDIRECT ----------------
        set_ex(1, 0, 1, 3'b000, 32'h44, 32'h2000, 0, 0, 0);
        tick();   // now in the redirect cycle
        idle();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_redirect", 32'(redirect), 32'd0);
        check("midrst_flush", 32'(flush), 32'd0);
        check("midrst_squash", 32'(squash_active), 32'd0);
        check("midrst_br_count", br_count, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            check("midrst_if_pred", 32'(if_pred_taken), 32'd0);
        end
        reset_model();
        @(negedge clk);
        rst = 1'b0;
        set_ex(1, 1, 0, 3'b000, 32'h0, 32'h20, 1, 0, 0);
        tick();

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 400; n++) begin
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_is_jump    = ($urandom_range(0, 7) == 0);
            ex_is_branch  = ($urandom_range(0, 4) != 0);
            ex_funct3     = 3'($urandom_range(0, 7));
            ex_pc         = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) ex_pc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            ex_target     = {$urandom} & 32'hFFFF_FFFC;
            ex_pred_taken = 1'($urandom_range(0, 1));
            BrEq          = 1'($urandom_range(0, 1));
            BrLT          = 1'($urandom_range(0, 1));
            if_pc         = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            tick();
        end

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
